// File: rtl/calc_engine_n.sv
// calc_engine_n: N-digit decimal calculator engine with edge-detected key entry,
// restoring divider, double-dabble converter and ASCII line buffer. Option macro: CALC_SIGNED_SUB_EN.
module calc_engine_n #(
  parameter int DIGITS   = 3,
  parameter int LINE_LEN = 16,
  localparam int OPW = $clog2(10**DIGITS),
  localparam int RW  = 2*OPW,
  localparam int AW  = $clog2(LINE_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [9:0]    KEY,
  input  logic          Add,
  input  logic          Sub,
  input  logic          Mul,
  input  logic          Div,
  input  logic          Eq,
  input  logic          Clr,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_char,
  output logic          busy,
  output logic          err,
  output logic [4:0]    led
);
  localparam int AB  = 4*DIGITS;
  localparam int BW  = 8*DIGITS;
  localparam int CW  = 8;
  localparam int CNW = $clog2(DIGITS+1);
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;

  typedef enum logic [2:0] {S_ENTER_A, S_ENTER_B, S_DIVIDE, S_CONVERT, S_FORMAT, S_DONE, S_ERROR} state_t;
  typedef enum logic [2:0] {EV_NONE, EV_DIGIT, EV_OP, EV_EQ, EV_CLR} ev_t;

  state_t r_state, w_state_nxt, r_ret;
  logic [15:0] r_in, r_prev, w_rise;
  ev_t r_ev_kind, w_ev_kind;
  logic [3:0] r_ev_val, w_ev_val;
  logic [OPW-1:0] r_a, r_b, r_quo, r_rem, w_cur_bin, w_num_nxt, w_rem_nxt, w_quo_nxt;
  logic [AB-1:0] r_a_bcd, r_b_bcd;
  logic [CNW-1:0] r_cnt_a, r_cnt_b, w_cur_cnt;
  logic [1:0] r_op;
  logic r_err, r_neg;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_dd_bin, w_res;
  logic [BW-1:0] r_dd_bcd, w_a_ext, w_b_ext;
  logic [OPW:0] w_trial;
  logic [7:0] r_buf [LINE_LEN];
  logic [7:0] w_char, w_op_char;
  logic w_busy_st, w_act_clr, w_act_dig, w_act_new, w_act_opa, w_act_opb, w_act_eq;
  logic w_sub_neg, w_neg_err, w_eq_err;

  function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] v, input logic b);
    logic [BW-1:0] adj;
    adj = v;
    for (int i = 0; i < 2*DIGITS; i++)
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    return {adj[BW-2:0], b};
  endfunction

  function automatic int sig_len(input logic [BW-1:0] v);
    int n;
    n = 1;
    for (int i = 0; i < 2*DIGITS; i++)
      if (v[4*i +: 4] != 4'd0) n = i + 1;
    return n;
  endfunction

  function automatic logic [7:0] dchar(input logic [BW-1:0] v, input int idx);
    return {4'h3, v[4*idx +: 4]};
  endfunction

  // Key pins -> input register -> prioritised edge event register.
  assign w_rise = r_in & ~r_prev;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_ev_kind = EV_NONE;
    w_ev_val  = 4'd0;
    for (int i = 0; i < 10; i++)
      if (w_rise[i]) begin w_ev_kind = EV_DIGIT; w_ev_val = 4'(i); end
    if (w_rise[10]) begin w_ev_kind = EV_OP; w_ev_val = {2'b00, OP_DIV}; end
    if (w_rise[11]) begin w_ev_kind = EV_OP; w_ev_val = {2'b00, OP_MUL}; end
    if (w_rise[12]) begin w_ev_kind = EV_OP; w_ev_val = {2'b00, OP_SUB}; end
    if (w_rise[13]) begin w_ev_kind = EV_OP; w_ev_val = {2'b00, OP_ADD}; end
    if (w_rise[14]) w_ev_kind = EV_EQ;
    if (w_rise[15]) w_ev_kind = EV_CLR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in      <= '0;
      r_prev    <= '0;
      r_ev_kind <= EV_NONE;
      r_ev_val  <= 4'd0;
    end else begin
      r_in      <= {Clr, Eq, Add, Sub, Mul, Div, KEY};
      r_prev    <= r_in;
      r_ev_kind <= w_ev_kind;
      r_ev_val  <= w_ev_val;
    end
  end

  assign w_cur_bin = (r_state == S_ENTER_B) ? r_b : r_a;
  assign w_cur_cnt = (r_state == S_ENTER_B) ? r_cnt_b : r_cnt_a;
  assign w_num_nxt = {w_cur_bin[OPW-4:0], 3'b000} + {w_cur_bin[OPW-2:0], 1'b0} + {{(OPW-4){1'b0}}, r_ev_val};
  assign w_act_clr = (r_ev_kind == EV_CLR) && !w_busy_st;
  assign w_act_dig = (r_ev_kind == EV_DIGIT) && (r_state == S_ENTER_A || r_state == S_ENTER_B)
                     && (w_cur_cnt != CNW'(DIGITS));
  assign w_act_new = (r_ev_kind == EV_DIGIT) && (r_state == S_DONE);
  assign w_act_opa = (r_ev_kind == EV_OP) && (r_state == S_ENTER_A) && (r_cnt_a != '0);
  assign w_act_opb = (r_ev_kind == EV_OP) && (r_state == S_ENTER_B) && (r_cnt_b == '0);
  assign w_act_eq  = (r_ev_kind == EV_EQ) && (r_state == S_ENTER_B) && (r_cnt_b != '0);
  assign w_sub_neg = (r_op == OP_SUB) && (r_a < r_b);
`ifdef CALC_SIGNED_SUB_EN
  assign w_neg_err = 1'b0;
`else
  assign w_neg_err = w_sub_neg;
`endif
  assign w_eq_err = ((r_op == OP_DIV) && (r_b == '0)) || w_neg_err;

  always_comb begin
    case (r_op)
      OP_ADD:  w_res = RW'(r_a) + RW'(r_b);
      OP_SUB:  w_res = w_sub_neg ? RW'(r_b - r_a) : RW'(r_a - r_b);
      OP_MUL:  w_res = RW'(r_a) * RW'(r_b);
      default: w_res = '0;
    endcase
  end

  // Restoring divider step: dividend bits shift out of r_quo into the remainder.
  assign w_trial   = {r_rem, r_quo[OPW-1]} - {1'b0, r_b};
  assign w_rem_nxt = w_trial[OPW] ? {r_rem[OPW-2:0], r_quo[OPW-1]} : w_trial[OPW-1:0];
  assign w_quo_nxt = {r_quo[OPW-2:0], ~w_trial[OPW]};

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    led         = 5'b00001;
    case (r_state)
      S_ENTER_A: led = 5'b00001;
      S_ENTER_B: led = 5'b00010;
      S_DIVIDE:  begin busy = 1'b1; led = 5'b00100; end
      S_CONVERT: begin busy = 1'b1; led = 5'b01000; end
      S_FORMAT:  begin busy = 1'b1; led = 5'b01100; end
      S_DONE:    led = 5'b10000;
      default:   led = 5'b11111;
    endcase
    case (r_state)
      S_DIVIDE:  if (r_cnt == CW'(OPW-1)) w_state_nxt = S_CONVERT;
      S_CONVERT: if (r_cnt == CW'(RW-1)) w_state_nxt = S_FORMAT;
      S_FORMAT:  if (r_cnt == CW'(LINE_LEN-1)) w_state_nxt = r_ret;
      default: begin
        if (w_act_clr || w_act_dig || w_act_new || w_act_opa || w_act_opb) w_state_nxt = S_FORMAT;
        else if (w_act_eq) begin
          if (w_eq_err)             w_state_nxt = S_FORMAT;
          else if (r_op == OP_DIV)  w_state_nxt = S_DIVIDE;
          else                      w_state_nxt = S_CONVERT;
        end
      end
    endcase
  end
  assign w_busy_st = busy;
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_ENTER_A;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || w_act_clr) begin
      r_a <= '0; r_b <= '0; r_a_bcd <= '0; r_b_bcd <= '0;
      r_cnt_a <= '0; r_cnt_b <= '0; r_op <= OP_ADD; r_err <= 1'b0; r_neg <= 1'b0;
      r_quo <= '0; r_rem <= '0; r_dd_bin <= '0; r_dd_bcd <= '0;
      r_cnt <= '0; r_ret <= S_ENTER_A;
    end else begin
      r_cnt <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
      if (w_act_dig) begin
        if (r_state == S_ENTER_A) begin
          r_a <= w_num_nxt; r_a_bcd <= {r_a_bcd[AB-5:0], r_ev_val}; r_cnt_a <= r_cnt_a + 1'b1;
        end else begin
          r_b <= w_num_nxt; r_b_bcd <= {r_b_bcd[AB-5:0], r_ev_val}; r_cnt_b <= r_cnt_b + 1'b1;
        end
        r_ret <= r_state;
      end
      if (w_act_new) begin
        r_a <= {{(OPW-4){1'b0}}, r_ev_val}; r_a_bcd <= {{(AB-4){1'b0}}, r_ev_val}; r_cnt_a <= CNW'(1);
        r_b <= '0; r_b_bcd <= '0; r_cnt_b <= '0; r_op <= OP_ADD; r_neg <= 1'b0; r_ret <= S_ENTER_A;
      end
      if (w_act_opa || w_act_opb) begin
        r_op  <= r_ev_val[1:0];
        r_ret <= S_ENTER_B;
      end
      if (w_act_eq) begin
        r_dd_bcd <= '0;
        if (w_eq_err) begin
          r_err <= 1'b1; r_ret <= S_ERROR;
        end else begin
          r_ret <= S_DONE; r_neg <= w_sub_neg; r_dd_bin <= w_res; r_quo <= r_a; r_rem <= '0;
        end
      end
      if (r_state == S_DIVIDE) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        if (r_cnt == CW'(OPW-1)) r_dd_bin <= RW'(w_quo_nxt);
      end
      if (r_state == S_CONVERT) begin
        r_dd_bin <= {r_dd_bin[RW-2:0], 1'b0};
        r_dd_bcd <= dd_step(r_dd_bcd, r_dd_bin[RW-1]);
      end
    end
  end

  // Character for line position r_cnt, derived from operands, operator and result.
  assign w_a_ext = {{(BW-AB){1'b0}}, r_a_bcd};
  assign w_b_ext = {{(BW-AB){1'b0}}, r_b_bcd};
  always_comb begin
    case (r_op)
      OP_ADD:  w_op_char = 8'h2B;
      OP_SUB:  w_op_char = 8'h2D;
      OP_MUL:  w_op_char = 8'h2A;
      default: w_op_char = 8'h2F;
    endcase
  end

  always_comb begin
    int p, base, la, lb, lr;
    w_char = 8'h20;
    p      = int'(r_cnt);
    base   = 0;
    la     = sig_len(w_a_ext);
    lb     = sig_len(w_b_ext);
    lr     = sig_len(r_dd_bcd);
    if (r_ret == S_ERROR) begin
      if (p == 0) w_char = 8'h45;
      else if (p == 1 || p == 2) w_char = 8'h52;
    end else begin
      if (p < la) w_char = dchar(w_a_ext, la - 1 - p);
      base = la;
      if (r_ret == S_ENTER_B || r_ret == S_DONE) begin
        if (p == base) w_char = w_op_char;
        base = base + 1;
        if (r_cnt_b != '0) begin
          if (p >= base && p < base + lb) w_char = dchar(w_b_ext, lb - 1 - (p - base));
          base = base + lb;
        end
      end
      if (r_ret == S_DONE) begin
        if (p == base) w_char = 8'h3D;
        base = base + 1;
        if (r_neg) begin
          if (p == base) w_char = 8'h2D;
          base = base + 1;
        end
        if (p >= base && p < base + lr) w_char = dchar(r_dd_bcd, lr - 1 - (p - base));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the line buffer is reset element by element because its reset contents are visible.
      for (int i = 0; i < LINE_LEN; i++) r_buf[i] <= (i == 0) ? 8'h30 : 8'h20;
    end else if (r_state == S_FORMAT) begin
      r_buf[r_cnt[AW-1:0]] <= w_char;
    end
  end

  assign rd_char = (int'(rd_addr) < LINE_LEN) ? r_buf[rd_addr] : 8'h20;
endmodule

// File: tb/tb_calc_engine_n.sv
// tb_calc_engine_n: scoreboard bench for calc_engine_n; busy lengths and line contents
// are queued when keys are driven and compared when the engine goes idle.
module tb_calc_engine_n;
  localparam int K_DIV = 10, K_MUL = 11, K_SUB = 12, K_ADD = 13, K_EQ = 14, K_CLR = 15;
  localparam int RW = 20, OPW = 10, LL = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [9:0] KEY;
  logic Add, Sub, Mul, Div, Eq, Clr;
  logic [3:0] rd_addr;
  logic [7:0] rd_char;
  logic busy, err;
  logic [4:0] led;

  int n_err = 0;
  int n_chk = 0;
  int q_busy[$];
  logic [127:0] q_line[$];

  calc_engine_n dut (
    .clk(clk), .rst_n(rst_n), .KEY(KEY), .Add(Add), .Sub(Sub), .Mul(Mul), .Div(Div),
    .Eq(Eq), .Clr(Clr), .rd_addr(rd_addr), .rd_char(rd_char), .busy(busy), .err(err), .led(led)
  );

  always #20 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [15:0] kb(input int i);
    return 16'h0001 << i;
  endfunction

  function automatic logic [127:0] mk(input string s);
    logic [127:0] v;
    v = {16{8'h20}};
    for (int i = 0; i < s.len() && i < 16; i++) v[8*(15-i) +: 8] = s[i];
    return v;
  endfunction

  task automatic drive_keys(input logic [15:0] k);
    KEY = k[9:0]; Div = k[10]; Mul = k[11]; Sub = k[12]; Add = k[13]; Eq = k[14]; Clr = k[15];
  endtask

  // Pulse keys for one cycle and measure the busy window (exp < 0: length not checked).
  task automatic press(input logic [15:0] k, input int exp_busy);
    int seen, exp;
    q_busy.push_back(exp_busy);
    @(negedge clk); drive_keys(k);
    @(negedge clk); drive_keys(16'h0000);
    seen = 0;
    for (int i = 0; i < 6 && !busy; i++) @(negedge clk);
    while (busy && seen < 300) begin seen++; @(negedge clk); end
    exp = q_busy.pop_front();
    if (exp >= 0) begin
      n_chk++;
      if (seen !== exp) begin
        n_err++;
        $display("FAIL busy_len keys=%h: got %0d cycles, want %0d", k, seen, exp);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic type_digits(input string s);
    for (int i = 0; i < s.len(); i++) press(kb(int'(s[i]) - 48), LL);
  endtask

  task automatic check_line(input string name, input string s);
    logic [127:0] got, exp;
    q_line.push_back(mk(s));
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      got[8*(15-a) +: 8] = rd_char;
    end
    exp = q_line.pop_front();
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL line_%s: got \"%s\" want \"%s\"", name, got, exp);
    end
  endtask

  task automatic test_reset;
    drive_keys(16'h0000); rd_addr = 4'd0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    n_chk++; if (led !== 5'b00001) begin n_err++; $display("FAIL reset_led: got %b want 00001", led); end
    check_line("reset", "0");
  endtask

  task automatic test_entry;
    type_digits("123");
    press(kb(4), 0);
    check_line("entry", "123");
    n_chk++; if (led !== 5'b00001) begin n_err++; $display("FAIL entry_led: got %b want 00001", led); end
    press(kb(K_CLR), LL);
    check_line("clr", "0");
    press(kb(K_ADD), 0);
    press(kb(K_EQ), 0);
    press(kb(3) | kb(7), LL);
    check_line("digit_prio", "7");
    press(kb(K_CLR) | kb(5), LL);
    check_line("clr_prio", "0");
  endtask

  task automatic test_op_replace;
    type_digits("12");
    press(kb(K_ADD), LL);
    press(kb(K_SUB), LL);
    type_digits("9");
    press(kb(K_EQ), RW + LL);
    check_line("op_replace", "12-9=3");
    n_chk++; if (led !== 5'b10000) begin n_err++; $display("FAIL done_led: got %b want 10000", led); end
  endtask

  task automatic test_mul;
    press(kb(9), LL);
    check_line("new_calc", "9");
    type_digits("99");
    press(kb(K_MUL), LL);
    type_digits("999");
    press(kb(K_EQ), RW + LL);
    check_line("mul", "999*999=998001");
  endtask

  task automatic test_div;
    press(kb(K_CLR), LL);
    type_digits("100");
    press(kb(K_DIV), LL);
    type_digits("7");
    press(kb(K_EQ), OPW + RW + LL);
    check_line("div", "100/7=14");
  endtask

  task automatic test_div0;
    press(kb(K_CLR), LL);
    type_digits("7");
    press(kb(K_DIV), LL);
    type_digits("0");
    press(kb(K_EQ), -1);
    n_chk++; if (err !== 1'b1) begin n_err++; $display("FAIL div0_err: got %b want 1", err); end
    n_chk++; if (led !== 5'b11111) begin n_err++; $display("FAIL div0_led: got %b want 11111", led); end
    check_line("div0", "ERR");
    press(kb(5), 0);
    check_line("err_ignore", "ERR");
    press(kb(K_CLR), LL);
    check_line("err_clr", "0");
    n_chk++; if (err !== 1'b0) begin n_err++; $display("FAIL clr_err: got %b want 0", err); end
  endtask

  task automatic test_sub_neg;
    type_digits("3");
    press(kb(K_SUB), LL);
    type_digits("8");
`ifdef CALC_SIGNED_SUB_EN
    press(kb(K_EQ), RW + LL);
    check_line("sub_neg", "3-8=-5");
    n_chk++; if (err !== 1'b0) begin n_err++; $display("FAIL sub_neg_err: got %b want 0", err); end
`else
    press(kb(K_EQ), -1);
    check_line("sub_neg", "ERR");
    n_chk++; if (err !== 1'b1) begin n_err++; $display("FAIL sub_neg_err: got %b want 1", err); end
`endif
    press(kb(K_CLR), LL);
  endtask

  task automatic test_reset_mid_divide;
    type_digits("100");
    press(kb(K_DIV), LL);
    type_digits("7");
    @(negedge clk); Eq = 1'b1;
    @(negedge clk); Eq = 1'b0;
    for (int i = 0; i < 10 && led !== 5'b00100; i++) @(negedge clk);
    n_chk++; if (led !== 5'b00100) begin n_err++; $display("FAIL reach_divide: got %b want 00100", led); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_chk++; if (led !== 5'b00001) begin n_err++; $display("FAIL mid_rst_led: got %b want 00001", led); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_chk++; if (err !== 1'b0) begin n_err++; $display("FAIL mid_rst_err: got %b want 0", err); end
    check_line("mid_rst", "0");
    repeat (60) @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_idle: got %b want 0", busy); end
    check_line("mid_rst_settled", "0");
  endtask

  initial begin
    test_reset();
    test_entry();
    test_op_replace();
    test_mul();
    test_div();
    test_div0();
    test_sub_neg();
    test_reset_mid_divide();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
